// File: rtl/bip_control.sv
// BIP1 control unit: program counter, instruction decode and run/halt sequencing.
module bip_control #(
  parameter int NB_INSTR   = 16,
  parameter int NB_OPCODE  = 5,
  parameter int NB_OPERAND = 11,
  parameter int NB_ADDR    = 11,
  parameter int NB_CNT     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [NB_INSTR-1:0]   i_instruction,
  output logic [NB_ADDR-1:0]    o_pc,
  output logic [NB_OPERAND-1:0] o_operand,
  output logic [1:0]            o_SelA,
  output logic                  o_SelB,
  output logic                  o_WrAcc,
  output logic                  o_op,
  output logic                  o_WrRam,
  output logic                  o_RdRam,
  output logic                  o_halt,
  output logic [NB_CNT-1:0]     o_cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
  localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
  localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
  localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
  localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
  localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
  localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
  localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);

  localparam logic [NB_ADDR-1:0] PC_ONE  = NB_ADDR'(1);
  localparam logic [NB_CNT-1:0]  CNT_ONE = NB_CNT'(1);

  state_t                state_q, state_d;
  logic [NB_ADDR-1:0]    pc_q, pc_d;
  logic [NB_CNT-1:0]     cnt_q, cnt_d;
  logic                  halt_q, halt_d;

  logic [NB_OPCODE-1:0]  opcode;
  logic                  is_hlt;

  assign opcode = i_instruction[NB_INSTR-1 -: NB_OPCODE];

  // Combinational decode: controls are only live in RUN so IDLE/HALT never strobe the datapath.
  always_comb begin
    o_SelA    = 2'b00;
    o_SelB    = 1'b0;
    o_WrAcc   = 1'b0;
    o_op      = 1'b0;
    o_WrRam   = 1'b0;
    o_RdRam   = 1'b0;
    o_operand = '0;
    is_hlt    = 1'b0;
    if (state_q == ST_RUN) begin
      o_operand = i_instruction[NB_OPERAND-1:0];
      case (opcode)
        OP_HLT: begin
          is_hlt    = 1'b1;
          o_operand = '0;
        end
        OP_STO:  o_WrRam = 1'b1;
        OP_LD: begin
          o_SelA  = 2'b00;
          o_WrAcc = 1'b1;
          o_RdRam = 1'b1;
        end
        OP_LDI: begin
          o_SelA  = 2'b01;
          o_WrAcc = 1'b1;
        end
        OP_ADD: begin
          o_SelA  = 2'b10;
          o_WrAcc = 1'b1;
          o_RdRam = 1'b1;
        end
        OP_ADDI: begin
          o_SelA  = 2'b10;
          o_SelB  = 1'b1;
          o_WrAcc = 1'b1;
        end
        OP_SUB: begin
          o_SelA  = 2'b10;
          o_op    = 1'b1;
          o_WrAcc = 1'b1;
          o_RdRam = 1'b1;
        end
        OP_SUBI: begin
          o_SelA  = 2'b10;
          o_SelB  = 1'b1;
          o_op    = 1'b1;
          o_WrAcc = 1'b1;
        end
        default: ;  // remaining opcodes behave as NOP: operand passes, no strobes
      endcase
    end
  end

  // Next-state: PC advances except on HLT, counter saturates, HALT is only left through reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    halt_d  = halt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
        if (is_hlt) begin
          state_d = ST_HALT;
          halt_d  = 1'b1;
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over all updates.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_cycle_count = cnt_q;
  assign o_halt        = halt_q;

endmodule

// File: tb/tb_bip_control.sv
// Bench for bip_control: spec-level model checked every cycle, plus directed literal expectations.
module tb_bip_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] instr = 16'h0000;

  always #5 clk = ~clk;

  // default-size instance
  logic [10:0] pc_a;
  logic [10:0] opnd_a;
  logic [1:0]  sela_a;
  logic        selb_a, wracc_a, op_a, wrram_a, rdram_a, halt_a;
  logic [15:0] cnt_a;
  // 3-bit PC instance for the wrap check
  logic [2:0]  pc_b;
  logic [10:0] opnd_b;
  logic [1:0]  sela_b;
  logic        selb_b, wracc_b, op_b, wrram_b, rdram_b, halt_b;
  logic [15:0] cnt_b;

  bip_control u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_instruction(instr),
    .o_pc(pc_a), .o_operand(opnd_a), .o_SelA(sela_a), .o_SelB(selb_a),
    .o_WrAcc(wracc_a), .o_op(op_a), .o_WrRam(wrram_a), .o_RdRam(rdram_a),
    .o_halt(halt_a), .o_cycle_count(cnt_a)
  );

  bip_control #(.NB_ADDR(3)) u_dut_small (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_instruction(instr),
    .o_pc(pc_b), .o_operand(opnd_b), .o_SelA(sela_b), .o_SelB(selb_b),
    .o_WrAcc(wracc_b), .o_op(op_b), .o_WrRam(wrram_b), .o_RdRam(rdram_b),
    .o_halt(halt_b), .o_cycle_count(cnt_b)
  );

  // control word {SelA[1:0], SelB, WrAcc, op, WrRam, RdRam}
  wire [6:0] ctrl_a = {sela_a, selb_a, wracc_a, op_a, wrram_a, rdram_a};
  wire [6:0] ctrl_b = {sela_b, selb_b, wracc_b, op_b, wrram_b, rdram_b};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Decode table straight from the opcode list.
  function automatic logic [6:0] ctrl_of(input logic [4:0] opc);
    case (opc)
      5'd1:    return 7'b00_0_0_0_1_0;  // STO
      5'd2:    return 7'b00_0_1_0_0_1;  // LD
      5'd3:    return 7'b01_0_1_0_0_0;  // LDI
      5'd4:    return 7'b10_0_1_0_0_1;  // ADD
      5'd5:    return 7'b10_1_1_0_0_0;  // ADDI
      5'd6:    return 7'b10_0_1_1_0_1;  // SUB
      5'd7:    return 7'b10_1_1_1_0_0;  // SUBI
      default: return 7'b0;             // HLT and NOPs
    endcase
  endfunction

  // Model: mode 0=idle 1=run 2=halt, unbounded pc reduced modulo address space at compare time.
  int m_mode = 0;
  int m_pc   = 0;
  int m_cnt  = 0;
  bit chk_en = 1'b0;

  // Model update on each rising edge from the architectural rules.
  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0;
      m_pc   <= 0;
      m_cnt  <= 0;
      chk_en <= 1'b1;
    end else if (m_mode == 0) begin
      if (start) m_mode <= 1;
    end else if (m_mode == 1) begin
      m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      if (instr[15:11] == 5'd0) m_mode <= 2;
      else m_pc <= m_pc + 1;
    end
  end

  // Per-cycle compare, mid low phase with inputs settled.
  always begin : cmp
    logic [6:0]  e_ctrl;
    logic [10:0] e_opnd;
    @(negedge clk);
    #2;
    if (chk_en) begin
      e_ctrl = (m_mode == 1) ? ctrl_of(instr[15:11]) : 7'b0;
      e_opnd = (m_mode == 1 && instr[15:11] != 5'd0) ? instr[10:0] : 11'd0;
      chk("pc",       32'(pc_a),   32'(m_pc % 2048));
      chk("pc_small", 32'(pc_b),   32'(m_pc % 8));
      chk("ctrl",     32'(ctrl_a), 32'(e_ctrl));
      chk("ctrl_small", 32'(ctrl_b), 32'(e_ctrl));
      chk("operand",  32'(opnd_a), 32'(e_opnd));
      chk("halt",     32'(halt_a), 32'(m_mode == 2));
      chk("count",    32'(cnt_a),  32'(m_cnt));
      chk("count_small", 32'(cnt_b), 32'(m_cnt));
    end
  end

  // Drive one cycle of inputs, then return just after the per-cycle compare.
  task automatic step(input logic r, input logic s, input logic [15:0] ins);
    @(negedge clk);
    rst   = r;
    start = s;
    instr = ins;
    #3;
    $display("cycle t=%0t rst=%0b start=%0b instr=%04h pc=%0d ctrl=%07b opnd=%0h halt=%0b cnt=%0d",
             $time, r, s, ins, pc_a, ctrl_a, opnd_a, halt_a, cnt_a);
  endtask

  logic [15:0] sweep_ins  [7] = '{16'h1801, 16'h2003, 16'h2805, 16'h3007, 16'h3809, 16'h0802, 16'h1004};
  logic [6:0]  sweep_ctrl [7] = '{7'b01_0_1_0_0_0, 7'b10_0_1_0_0_1, 7'b10_1_1_0_0_0, 7'b10_0_1_1_0_1,
                                  7'b10_1_1_1_0_0, 7'b00_0_0_0_1_0, 7'b00_0_1_0_0_1};
  int          sweep_opnd [7] = '{1, 3, 5, 7, 9, 2, 4};
  int          wrap_seq   [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

  initial begin
    // reset and idle: a valid LDI on the bus must not leak out
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 16'h1805);
      chk("idle_pc", 32'(pc_a), 32'd0);
      chk("idle_ctrl", 32'(ctrl_a), 32'd0);
    end
    chk("idle_cnt", 32'(cnt_a), 32'd0);

    // full decode sweep
    step(1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, sweep_ins[i]);
      chk("sweep_pc", 32'(pc_a), 32'(i));
      chk("sweep_ctrl", 32'(ctrl_a), 32'(sweep_ctrl[i]));
      chk("sweep_opnd", 32'(opnd_a), 32'(sweep_opnd[i]));
    end
    // invalid opcode 01000 behaves as NOP
    step(1'b0, 1'b0, 16'h4123);
    chk("sweep_cnt", 32'(cnt_a), 32'd7);
    chk("nop_pc", 32'(pc_a), 32'd7);
    chk("nop_ctrl", 32'(ctrl_a), 32'd0);
    chk("nop_opnd", 32'(opnd_a), 32'h123);
    step(1'b0, 1'b0, 16'hF800);
    chk("nop_pc_inc", 32'(pc_a), 32'd8);

    // PC wrap on the 3-bit instance
    step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 16'h4000);
      chk("wrap_pc", 32'(pc_b), 32'(wrap_seq[i]));
    end
    step(1'b0, 1'b0, 16'h4000);
    chk("wrap_pc_last", 32'(pc_b), 32'd1);
    chk("wide_pc", 32'(pc_a), 32'd9);

    // reset mid-run at pc=4
    step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h4000);
    step(1'b1, 1'b0, 16'h1801);
    chk("mid_pc_before", 32'(pc_a), 32'd4);
    step(1'b0, 1'b0, 16'h1801);
    chk("mid_pc_after", 32'(pc_a), 32'd0);
    chk("mid_cnt_after", 32'(cnt_a), 32'd0);
    chk("mid_ctrl_after", 32'(ctrl_a), 32'd0);
    step(1'b0, 1'b1, 16'h1801);
    step(1'b0, 1'b0, 16'h1801);
    chk("restart_pc", 32'(pc_a), 32'd0);
    chk("restart_ctrl", 32'(ctrl_a), 32'(7'b01_0_1_0_0_0));

    // halt program: LDI 5, ADDI 1, HLT
    step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 16'h1805);
    step(1'b0, 1'b0, 16'h2801);
    step(1'b0, 1'b0, 16'h07FF);
    chk("hlt_opnd", 32'(opnd_a), 32'd0);
    chk("hlt_ctrl", 32'(ctrl_a), 32'd0);
    chk("hlt_halt", 32'(halt_a), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 16'h1805);
      chk("halt_pc", 32'(pc_a), 32'd2);
      chk("halt_cnt", 32'(cnt_a), 32'd3);
      chk("halt_flag", 32'(halt_a), 32'd1);
      chk("halt_ctrl", 32'(ctrl_a), 32'd0);
    end

    // leaving HALT through reset
    step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    chk("post_halt_flag", 32'(halt_a), 32'd0);
    chk("post_halt_pc", 32'(pc_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
